// File: rtl/rv_pkg.sv
// Shared types and opcode constants for the multi-cycle RV32I control unit.
// Select encodings match the datapath mux wiring downstream.
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluc_t;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'b00,
    SRC1_PC   = 2'b01,
    SRC1_ZERO = 2'b10
  } src1_t;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'b00,
    SRC2_IMM  = 2'b01,
    SRC2_FOUR = 2'b10
  } src2_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_TGT   = 2'b01,
    PC_ALU   = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCINC  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // sub_en is only ever set for register-register ops; immediates have no SUBI
  function automatic aluc_t alu_from_funct(input logic [2:0] f3, input logic sub_en,
                                           input logic sra_en);
    case (f3)
      3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the opcode and
// sign-extends it to 32 bits. R-type and unknown opcodes produce zero.
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  always_comb begin
    case (ir[6:0])
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ir[31:12], 12'b0};
      OP_JAL:
        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control unit: owns the IR, sequences memory accesses and
// drives ALU opcode, operand muxes and PC/register-file strobes.
//
//  state  | meaning
//  IDLE   | post-reset, one cycle before the first fetch
//  FETCH  | instruction read at PC, IR loaded on mem_ready
//  DECODE | branch/JAL target PC+imm latched; illegal opcode halts
//  EXEC   | ALU op per class; branches and jumps retire here
//  MEM    | load/store access at latched address
//  WB     | register write-back and PC+4
//  PCINC  | store retirement, PC+4 only
//  HALT   | absorbing; left only through rst_n
module rv_ctrl_fsm
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [2:0]  mem_funct3,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        alu_zero,
  output logic [3:0]  aluc,
  output logic [1:0]  src1_sel,
  output logic [1:0]  src2_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        tgt_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        fault
);

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] ir;
  logic [15:0] tmo_cnt;
  logic        fault_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic        rd_nz;
  logic        tmo_hit;
  logic        is_alu_class;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign f7b5    = ir[30];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign rd      = ir[11:7];
  assign rd_nz   = |ir[11:7];
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);
  assign is_alu_class = (opcode == OP_OP) || (opcode == OP_OPIMM) ||
                        (opcode == OP_LUI) || (opcode == OP_AUIPC);

  rv_imm_gen u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir      <= IR_NOP;
      tmo_cnt <= 16'd0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_FETCH;
          tmo_cnt <= 16'd0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end else if (tmo_hit) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          if (op_legal(opcode)) begin
            state <= S_EXEC;
          end else begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_LOAD, OP_STORE: begin
              state   <= S_MEM;
              tmo_cnt <= 16'd0;
            end
            OP_BRANCH, OP_JAL, OP_JALR: begin
              state   <= S_FETCH;
              tmo_cnt <= 16'd0;
            end
            OP_SYSTEM: state <= S_HALT;
            default:   state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= (opcode == OP_STORE) ? S_PCINC : S_WB;
          end else if (tmo_hit) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_WB, S_PCINC: begin
          state   <= S_FETCH;
          tmo_cnt <= 16'd0;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  aluc_t   alu_op, br_op, aluc_c;
  src1_t   alu_s1, src1_c;
  src2_t   alu_s2, src2_c;
  pc_sel_t pc_sel_c;
  wb_sel_t wb_sel_c;
  logic    br_taken;

  always_comb begin
    alu_op = ALU_ADD;
    alu_s1 = SRC1_RS1;
    alu_s2 = SRC2_RS2;
    case (opcode)
      OP_OP:    alu_op = alu_from_funct(funct3, f7b5, f7b5);
      OP_OPIMM: begin
        alu_op = alu_from_funct(funct3, 1'b0, f7b5);
        alu_s2 = SRC2_IMM;
      end
      OP_LUI: begin
        alu_s1 = SRC1_ZERO;
        alu_s2 = SRC2_IMM;
      end
      OP_AUIPC: begin
        alu_s1 = SRC1_PC;
        alu_s2 = SRC2_IMM;
      end
      default: ;
    endcase
  end

  // BLT/BLTU compare result is 1 when taken, so they share BNE's "!zero" sense
  always_comb begin
    case (funct3[2:1])
      2'b10:   br_op = ALU_SLT;
      2'b11:   br_op = ALU_SLTU;
      default: br_op = ALU_SUB;
    endcase
    case (funct3)
      3'b000, 3'b101, 3'b111: br_taken = alu_zero;
      3'b001, 3'b100, 3'b110: br_taken = !alu_zero;
      default:                br_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_funct3   = 3'd0;
    aluc_c       = ALU_ADD;
    src1_c       = SRC1_RS1;
    src2_c       = SRC2_RS2;
    tgt_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel_c     = PC_PLUS4;
    reg_we       = 1'b0;
    wb_sel_c     = WB_ALU;
    case (state)
      S_FETCH: mem_req = 1'b1;
      S_DECODE: begin
        src1_c = SRC1_PC;
        src2_c = SRC2_IMM;
        tgt_we = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: begin
            aluc_c = alu_op;
            src1_c = alu_s1;
            src2_c = alu_s2;
          end
          OP_LOAD, OP_STORE: begin
            src2_c = SRC2_IMM;
            tgt_we = 1'b1;
          end
          OP_BRANCH: begin
            aluc_c   = br_op;
            pc_we    = 1'b1;
            pc_sel_c = br_taken ? PC_TGT : PC_PLUS4;
          end
          OP_JAL: begin
            reg_we   = rd_nz;
            wb_sel_c = WB_PC4;
            pc_we    = 1'b1;
            pc_sel_c = PC_TGT;
          end
          OP_JALR: begin
            src2_c   = SRC2_IMM;
            reg_we   = rd_nz;
            wb_sel_c = WB_PC4;
            pc_we    = 1'b1;
            pc_sel_c = PC_ALU;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        mem_funct3   = funct3;
      end
      S_WB: begin
        // ALU controls held so the result being written is still on the ALU output
        if (is_alu_class) begin
          aluc_c = alu_op;
          src1_c = alu_s1;
          src2_c = alu_s2;
        end
        reg_we   = rd_nz;
        pc_we    = 1'b1;
        wb_sel_c = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
      end
      S_PCINC: pc_we = 1'b1;
      default: ;
    endcase
  end

  assign aluc     = aluc_c;
  assign src1_sel = src1_c;
  assign src2_sel = src2_c;
  assign pc_sel   = pc_sel_c;
  assign wb_sel   = wb_sel_c;
  assign halted   = (state == S_HALT);
  assign fault    = fault_q;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Bench for rv_ctrl_fsm: table of instructions with expected EXEC and
// retirement controls, scoreboard queue, plus halt/timeout/reset sequences.
module tb_rv_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [2:0]  mem_funct3;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        alu_zero;
  logic [3:0]  aluc;
  logic [1:0]  src1_sel, src2_sel;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        tgt_we, pc_we;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        halted, fault;

  int n_err = 0;
  int n_checks = 0;

  rv_ctrl_fsm #(.TIMEOUT_CYCLES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .mem_funct3   (mem_funct3),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .alu_zero     (alu_zero),
    .aluc         (aluc),
    .src1_sel     (src1_sel),
    .src2_sel     (src2_sel),
    .imm          (imm),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .tgt_we       (tgt_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  e_aluc;
    logic [1:0]  e_src1;
    logic [1:0]  e_src2;
    logic [31:0] e_imm;
    logic        mem_acc;
    logic        mem_we;
    logic [1:0]  r_pc_sel;
    logic        r_reg_we;
    logic [1:0]  r_wb_sel;
    int          cycles;
  } vec_t;

  vec_t vecs[15];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, mem_req, 1);
  endtask

  task automatic fetch(input logic [31:0] instr);
    wait_req("fetch_req");
    mem_rdata = instr;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int waits);
    vec_t e;
    int n;
    int k;
    logic seen, seen_we, seen_as;
    logic [2:0] seen_f3;
    exp_q.push_back(v);
    alu_zero = v.zero;
    wait_req($sformatf("v%0d_req", idx));
    n = 1;
    repeat (waits) begin
      @(negedge clk);
      n++;
    end
    mem_rdata = v.instr;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n++;
    chk($sformatf("v%0d_decode", idx), {tgt_we, aluc, src1_sel, src2_sel, pc_we},
        {1'b1, 4'd0, 2'b01, 2'b01, 1'b0});
    @(negedge clk);
    n++;
    e = exp_q.pop_front();
    chk($sformatf("v%0d_exec_aluc", idx), aluc, e.e_aluc);
    chk($sformatf("v%0d_exec_src", idx), {src1_sel, src2_sel}, {e.e_src1, e.e_src2});
    chk($sformatf("v%0d_exec_imm", idx), imm, e.e_imm);
    seen = 1'b0; seen_we = 1'b0; seen_as = 1'b0; seen_f3 = 3'd0;
    k = 0;
    while (!pc_we && k < 10) begin
      if (mem_req) begin
        seen = 1'b1; seen_we = mem_we; seen_as = mem_addr_sel; seen_f3 = mem_funct3;
        mem_rdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      n++;
      k++;
    end
    chk($sformatf("v%0d_retire", idx), pc_we, 1);
    chk($sformatf("v%0d_mem_acc", idx), seen, e.mem_acc);
    if (e.mem_acc)
      chk($sformatf("v%0d_mem_ctl", idx), {seen_we, seen_as, seen_f3},
          {e.mem_we, 1'b1, e.instr[14:12]});
    chk($sformatf("v%0d_ret_ctl", idx), {pc_sel, reg_we, wb_sel},
        {e.r_pc_sel, e.r_reg_we, e.r_wb_sel});
    chk($sformatf("v%0d_cycles", idx), n - waits, e.cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //            instr         z     aluc  s1     s2     imm           mem  we    pcsel  rwe   wb     cyc
    vecs[0]  = '{32'h002081B3, 1'b0, 4'd0, 2'd0, 2'd0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4}; // ADD
    vecs[1]  = '{32'h40208233, 1'b0, 4'd1, 2'd0, 2'd0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4}; // SUB
    vecs[2]  = '{32'h4030D293, 1'b0, 4'd9, 2'd0, 2'd1, 32'h00000403, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4}; // SRAI
    vecs[3]  = '{32'hFFF08013, 1'b0, 4'd0, 2'd0, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4}; // ADDI x0
    vecs[4]  = '{32'h12345337, 1'b0, 4'd0, 2'd2, 2'd1, 32'h12345000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4}; // LUI
    vecs[5]  = '{32'hFFFFF397, 1'b0, 4'd0, 2'd1, 2'd1, 32'hFFFFF000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4}; // AUIPC
    vecs[6]  = '{32'h0020B433, 1'b0, 4'd6, 2'd0, 2'd0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4}; // SLTU
    vecs[7]  = '{32'h00209463, 1'b0, 4'd1, 2'd0, 2'd0, 32'h00000008, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 3}; // BNE taken
    vecs[8]  = '{32'h00209463, 1'b1, 4'd1, 2'd0, 2'd0, 32'h00000008, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3}; // BNE not
    vecs[9]  = '{32'h0020F463, 1'b0, 4'd6, 2'd0, 2'd0, 32'h00000008, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3}; // BGEU not
    vecs[10] = '{32'hFE20CEE3, 1'b0, 4'd5, 2'd0, 2'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 3}; // BLT taken
    vecs[11] = '{32'h010000EF, 1'b0, 4'd0, 2'd0, 2'd0, 32'h00000010, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 3}; // JAL
    vecs[12] = '{32'h00008067, 1'b0, 4'd0, 2'd0, 2'd1, 32'h00000000, 1'b0, 1'b0, 2'd2, 1'b0, 2'd2, 3}; // JALR x0
    vecs[13] = '{32'h00812283, 1'b0, 4'd0, 2'd0, 2'd1, 32'h00000008, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 5}; // LW
    vecs[14] = '{32'h00512623, 1'b0, 4'd0, 2'd0, 2'd1, 32'h0000000C, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 5}; // SW

    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    alu_zero = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ctl", {mem_req, mem_we, mem_addr_sel, mem_funct3, aluc, src1_sel, src2_sel, rs1, rs2,
                    rd, tgt_we, pc_we, pc_sel, reg_we, wb_sel, halted, fault}, 64'd0);
    chk("rst_imm", imm, 32'd0);
    rst_n = 1'b1;
    chk("idle_no_req", mem_req, 0);
    @(negedge clk);
    chk("first_req", mem_req, 1);

    for (int i = 0; i < 15; i++)
      run_vec(i, vecs[i], (i == 0) ? 2 : (i % 3));
    chk("sb_drain", exp_q.size(), 0);

    // illegal opcode right after the store
    fetch(32'h0000007F);
    chk("ill_decode_not_halted", halted, 0);
    @(negedge clk);
    chk("ill_halt", {halted, fault}, 2'b11);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req || pc_we || reg_we) cnt++;
    end
    chk("ill_no_activity", cnt, 0);
    chk("ill_sticky", {halted, fault}, 2'b11);

    // ECALL halts without fault
    do_reset();
    chk("rst_clears_fault", {halted, fault}, 2'b00);
    fetch(32'h00000073);
    @(negedge clk);
    chk("ecall_exec_not_halted", halted, 0);
    @(negedge clk);
    chk("ecall_halt", {halted, fault}, 2'b10);

    // fetch timeout with TIMEOUT_CYCLES=3
    do_reset();
    wait_req("tmo_req");
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (!mem_req) break;
      cnt++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", cnt, 3);
    chk("tmo_fault", {halted, fault}, 2'b11);

    // async reset in the middle of a load's memory access
    do_reset();
    fetch(32'h00812283);
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_req", {mem_req, mem_addr_sel, mem_we}, 3'b110);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", {mem_req, pc_we, reg_we, tgt_we}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", mem_req, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
